// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// Define AXIL_MASTER_TIMEOUT_EN to compile in the hung-bus watchdog.
module axil_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_write_i,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [DATA_W-1:0]   cmd_wdata_i,
   output logic                rsp_valid_o,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic [1:0]          rsp_resp_o,
   output logic                rsp_timeout_o,
   output logic [ADDR_W-1:0]   m_axi_awaddr_o,
   output logic                m_axi_awvalid_o,
   input  logic                m_axi_awready_i,
   output logic [2:0]          m_axi_awprot_o,
   output logic [DATA_W-1:0]   m_axi_wdata_o,
   output logic [DATA_W/8-1:0] m_axi_wstrb_o,
   output logic                m_axi_wvalid_o,
   input  logic                m_axi_wready_i,
   input  logic [1:0]          m_axi_bresp_i,
   input  logic                m_axi_bvalid_i,
   output logic                m_axi_bready_o,
   output logic [ADDR_W-1:0]   m_axi_araddr_o,
   output logic                m_axi_arvalid_o,
   input  logic                m_axi_arready_i,
   output logic [2:0]          m_axi_arprot_o,
   input  logic [DATA_W-1:0]   m_axi_rdata_i,
   input  logic [1:0]          m_axi_rresp_i,
   input  logic                m_axi_rvalid_i,
   output logic                m_axi_rready_o
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

   state_e              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_resp_q, rsp_resp_d;
   logic                timeout_hit;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] timer_q, timer_d;

   // Counts non-IDLE cycles; it is zero in the first cycle after acceptance.
   assign timer_d     = (state_q == IDLE) ? '0 : timer_q + 1'b1;
   assign timeout_hit = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) timer_q <= '0;
      else            timer_q <= timer_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               addr_d      = cmd_addr_i;
               wdata_d     = cmd_wdata_i;
               cmd_ready_d = 1'b0;
               if (cmd_write_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // AW and W retire independently; a channel already dropped counts as done.
            if (awvalid_q && m_axi_awready_i) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready_i)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid_i) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_resp_d    = m_axi_bresp_i;
               rsp_timeout_d = 1'b0;
               cmd_ready_d   = 1'b1;
               state_d       = IDLE;
            end
         end
         RD_REQ: begin
            if (m_axi_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (m_axi_rvalid_i) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = m_axi_rdata_i;
               rsp_resp_d    = m_axi_rresp_i;
               rsp_timeout_d = 1'b0;
               cmd_ready_d   = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Watchdog abort overrides any handshake in the same cycle.
      if (timeout_hit) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_rdata_d   = '0;
         rsp_resp_d    = 2'b10;
         rsp_timeout_d = 1'b1;
         cmd_ready_d   = 1'b1;
         state_d       = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b1;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready_o     = cmd_ready_q;
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign rsp_resp_o      = rsp_resp_q;
   assign rsp_timeout_o   = rsp_timeout_q;
   assign m_axi_awaddr_o  = addr_q;
   assign m_axi_awvalid_o = awvalid_q;
   assign m_axi_awprot_o  = 3'b000;
   assign m_axi_wdata_o   = wdata_q;
   assign m_axi_wstrb_o   = '1;
   assign m_axi_wvalid_o  = wvalid_q;
   assign m_axi_bready_o  = bready_q;
   assign m_axi_araddr_o  = addr_q;
   assign m_axi_arvalid_o = arvalid_q;
   assign m_axi_arprot_o  = 3'b000;
   assign m_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: the slave side is driven cycle by cycle from each scenario task.
// Build with +define+AXIL_MASTER_TIMEOUT_EN to exercise the watchdog path.
module tb_axil_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0;
   int errors = 0;

   axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
      .rsp_timeout_o(rsp_timeout),
      .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
      .m_axi_awprot_o(awprot),
      .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid),
      .m_axi_wready_i(wready),
      .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
      .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
      .m_axi_arprot_o(arprot),
      .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid),
      .m_axi_rready_o(rready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command for the accept edge N; returns in cycle N+1.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      repeat (2) tick();
      checks++;
      if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b1000000) begin
         errors++; $display("FAIL reset_handshake: got %b expected 1000000",
                            {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
      end
      checks++;
      if ({awaddr, araddr, wdata} !== 96'h0) begin
         errors++; $display("FAIL reset_addr_data: got %h expected 0", {awaddr, araddr, wdata});
      end
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin
         errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_rdata, rsp_resp, rsp_timeout});
      end
      checks++;
      if ({wstrb, awprot, arprot} !== 10'b1111_000_000) begin
         errors++; $display("FAIL fixed_fields: got %b expected 1111000000", {wstrb, awprot, arprot});
      end
      reset_n = 1'b1;
      tick();
      $display("txn reset released");
   endtask

   task automatic test_write_zero_wait();
      issue(1'b1, 32'h0, 32'h05);
      checks++;
      if ({awvalid, wvalid, bready, cmd_ready} !== 4'b1100 || awaddr !== 32'h0 ||
          wdata !== 32'h05 || wstrb !== 4'hF) begin
         errors++; $display("FAIL wr0_n1: got v=%b addr=%h data=%h strb=%h expected v=1100 addr=0 data=5 strb=f",
                            {awvalid, wvalid, bready, cmd_ready}, awaddr, wdata, wstrb);
      end
      awready = 1; wready = 1;
      tick();
      checks++;
      if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
         errors++; $display("FAIL wr0_n2: got %b expected 0010", {awvalid, wvalid, bready, rsp_valid});
      end
      awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
      tick();
      checks++;
      if ({rsp_valid, cmd_ready, bready} !== 3'b110 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL wr0_n3: got v=%b resp=%b rdata=%h expected v=110 resp=00 rdata=0",
                            {rsp_valid, cmd_ready, bready}, rsp_resp, rsp_rdata);
      end
      bvalid = 0;
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL wr0_pulse: got rsp_valid=%b expected 0", rsp_valid);
      end
      $display("txn write addr=00000000 data=00000005 resp=%b", rsp_resp);
   endtask

   task automatic test_read_zero_wait();
      issue(1'b0, 32'hC, 32'h0);
      checks++;
      if ({arvalid, rready, awvalid} !== 3'b100 || araddr !== 32'hC) begin
         errors++; $display("FAIL rd0_n1: got v=%b addr=%h expected v=100 addr=c", {arvalid, rready, awvalid}, araddr);
      end
      arready = 1;
      tick();
      checks++;
      if ({arvalid, rready, rsp_valid} !== 3'b010) begin
         errors++; $display("FAIL rd0_n2: got %b expected 010", {arvalid, rready, rsp_valid});
      end
      arready = 0; rvalid = 1; rdata = 32'h0000_0008; rresp = 2'b00;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8 || rsp_resp !== 2'b00 || rready !== 1'b0) begin
         errors++; $display("FAIL rd0_n3: got v=%b rdata=%h resp=%b rready=%b expected v=1 rdata=8 resp=00 rready=0",
                            rsp_valid, rsp_rdata, rsp_resp, rready);
      end
      rvalid = 0; rdata = 32'h0;
      repeat (2) tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h8) begin
         errors++; $display("FAIL rd0_hold: got v=%b rdata=%h expected v=0 rdata=8", rsp_valid, rsp_rdata);
      end
      $display("txn read addr=0000000c rdata=%h resp=%b", rsp_rdata, rsp_resp);
   endtask

   task automatic test_skewed_write();
      issue(1'b1, 32'h4, 32'hA5A5_0001);
      wready = 1;
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++; $display("FAIL skew_n1: got %b expected 11", {awvalid, wvalid});
      end
      tick();
      wready = 0;
      for (int c = 2; c <= 4; c++) begin
         checks++;
         if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h4) begin
            errors++; $display("FAIL skew_n%0d: got v=%b addr=%h expected v=100 addr=4", c, {awvalid, wvalid, bready}, awaddr);
         end
         if (c == 4) awready = 1;
         tick();
      end
      awready = 0;
      checks++;
      if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
         errors++; $display("FAIL skew_n5: got %b expected 0010", {awvalid, wvalid, bready, rsp_valid});
      end
      bvalid = 1; bresp = 2'b00;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL skew_n6: got v=%b resp=%b rdata=%h expected v=1 resp=00 rdata=0",
                            rsp_valid, rsp_resp, rsp_rdata);
      end
      bvalid = 0;
      tick();
      $display("txn skewed write addr=00000004 resp=%b", rsp_resp);
   endtask

   task automatic test_error_resp();
      issue(1'b1, 32'h8, 32'h1234);
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      tick();
      checks++;
      if (bready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL err_bwait: got bready=%b v=%b expected bready=1 v=0", bready, rsp_valid);
      end
      bvalid = 1; bresp = 2'b10;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_timeout !== 1'b0) begin
         errors++; $display("FAIL err_resp: got v=%b resp=%b to=%b expected v=1 resp=10 to=0",
                            rsp_valid, rsp_resp, rsp_timeout);
      end
      bvalid = 0; bresp = 2'b00;
      tick();
      $display("txn write addr=00000008 resp=%b timeout=%b", rsp_resp, rsp_timeout);
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 32'h10, 32'h0);
      // A write presented while busy must be ignored, then accepted in the rsp_valid cycle.
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'hBEEF;
      arready = 1;
      tick();
      checks++;
      if ({arvalid, rready, awvalid, cmd_ready} !== 4'b0100 || araddr !== 32'h10) begin
         errors++; $display("FAIL b2b_ignore: got v=%b addr=%h expected v=0100 addr=10",
                            {arvalid, rready, awvalid, cmd_ready}, araddr);
      end
      arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b01;
      tick();
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b11 || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'b01) begin
         errors++; $display("FAIL b2b_read: got v=%b rdata=%h resp=%b expected v=11 rdata=cafef00d resp=01",
                            {rsp_valid, cmd_ready}, rsp_rdata, rsp_resp);
      end
      rvalid = 0;
      $display("txn read addr=00000010 rdata=%h resp=%b", rsp_rdata, rsp_resp);
      tick();
      cmd_valid = 0;
      checks++;
      if ({awvalid, wvalid, arvalid} !== 3'b110 || awaddr !== 32'h20 || wdata !== 32'hBEEF) begin
         errors++; $display("FAIL b2b_accept: got v=%b addr=%h data=%h expected v=110 addr=20 data=beef",
                            {awvalid, wvalid, arvalid}, awaddr, wdata);
      end
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0; bvalid = 1;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL b2b_write: got v=%b resp=%b rdata=%h expected v=1 resp=00 rdata=0",
                            rsp_valid, rsp_resp, rsp_rdata);
      end
      bvalid = 0;
      tick();
      $display("txn write addr=00000020 data=0000beef resp=%b", rsp_resp);
   endtask

   task automatic test_reset_mid_write();
      bit seen_rsp = 0;
      issue(1'b1, 32'h30, 32'h77);
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      checks++;
      if (bready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre: got bready=%b expected 1", bready);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
         errors++; $display("FAIL rst_mid_async: got %b expected 0000001",
                            {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
      end
      repeat (2) tick();
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen_rsp = 1;
      end
      checks++;
      if (seen_rsp) begin
         errors++; $display("FAIL rst_mid_quiet: got spurious rsp_valid or cmd_ready low expected none");
      end
      issue(1'b1, 32'h34, 32'h99);
      checks++;
      if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h34 || wdata !== 32'h99) begin
         errors++; $display("FAIL rst_mid_next: got v=%b addr=%h data=%h expected v=11 addr=34 data=99",
                            {awvalid, wvalid}, awaddr, wdata);
      end
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0; bvalid = 1;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00) begin
         errors++; $display("FAIL rst_mid_done: got v=%b resp=%b expected v=1 resp=00", rsp_valid, rsp_resp);
      end
      bvalid = 0;
      tick();
      $display("txn reset mid-write then write addr=00000034 resp=%b", rsp_resp);
   endtask

   task automatic test_timeout();
`ifdef AXIL_MASTER_TIMEOUT_EN
      issue(1'b0, 32'h40, 32'h0);
      for (int c = 1; c <= 16; c++) begin
         checks++;
         if (arvalid !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL to_wait_n%0d: got arvalid=%b v=%b expected arvalid=1 v=0", c, arvalid, rsp_valid);
         end
         tick();
      end
      checks++;
      if ({arvalid, rsp_valid, rsp_timeout, cmd_ready} !== 4'b0111 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL to_fire: got v=%b resp=%b rdata=%h expected v=0111 resp=10 rdata=0",
                            {arvalid, rsp_valid, rsp_timeout, cmd_ready}, rsp_resp, rsp_rdata);
      end
      tick();
      $display("txn read addr=00000040 timed out resp=%b", rsp_resp);
`else
      bit dropped = 0;
      issue(1'b0, 32'h40, 32'h0);
      for (int c = 0; c < 40; c++) begin
         if (arvalid !== 1'b1 || rsp_valid !== 1'b0) dropped = 1;
         tick();
      end
      checks++;
      if (dropped) begin
         errors++; $display("FAIL no_timeout: got arvalid dropped or rsp_valid expected arvalid held");
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if ({arvalid, cmd_ready, rsp_timeout} !== 3'b010) begin
         errors++; $display("FAIL no_timeout_recover: got %b expected 010", {arvalid, cmd_ready, rsp_timeout});
      end
      $display("txn read addr=00000040 held without watchdog, recovered by reset");
`endif
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_zero_wait();
      test_skewed_write();
      test_error_resp();
      test_back_to_back();
      test_reset_mid_write();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
